// File: rtl/vid_pipe_pkg.sv
// Shared types and helpers for the video timing delay pipe.
//   state_t      : resync state machine encoding (RUN / PENDING / BLANK)
//   rgb24_t      : packed 24-bit RGB pixel
//   clamp_delay(): maps a raw delay request onto the legal range 1..max_delay
package vid_pipe_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PENDING = 2'd1,
        BLANK   = 2'd2
    } state_t;

    typedef logic [23:0] rgb24_t;

    // A request of 0 means "shortest", anything beyond the pipe depth
    // saturates at the deepest tap.
    function automatic int unsigned clamp_delay(input int unsigned sel,
                                                input int unsigned max_delay);
        if (sel == 0)
            return 1;
        else if (sel > max_delay)
            return max_delay;
        else
            return sel;
    endfunction

endpackage

// File: rtl/vid_timing_delay_pipe_tap.sv
// Generic WIDTH x DEPTH tick-enabled shift register with a variable tap.
// Stage 1 is the live input; stage n holds the input from n-1 ticks ago.
// On each tick dout loads the selected stage, so a tap of D gives an
// output that is D ticks behind the input (tap 1 = one plain register).
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   tick       : shift/load enable
//   din        : data entering the pipe
//   tap        : selected stage, 1..DEPTH (caller guarantees the range)
//   peek       : low PEEK_W bits of the selected stage, combinational, so
//                side logic can act on the value dout is about to load
//   dout       : registered tap output
module vid_tap_delay #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int PEEK_W = 1,
    parameter int DW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [WIDTH-1:0]  din,
    input  logic [DW-1:0]     tap,
    output logic [PEEK_W-1:0] peek,
    output logic [WIDTH-1:0]  dout
);

    logic [WIDTH-1:0] stage_reg [2:DEPTH];
    logic [WIDTH-1:0] sel_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 2; i <= DEPTH; i++)
                stage_reg[i] <= '0;
        end else if (tick) begin
            stage_reg[2] <= din;
            for (int i = 3; i <= DEPTH; i++)
                stage_reg[i] <= stage_reg[i-1];
        end
    end

    always_comb begin
        sel_data = din;
        for (int i = 2; i <= DEPTH; i++)
            if (tap == DW'(i))
                sel_data = stage_reg[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dout <= '0;
        else if (tick)
            dout <= sel_data;
    end

    assign peek = sel_data[PEEK_W-1:0];

endmodule

// File: rtl/vid_timing_delay_pipe.sv
// Runtime-programmable delay for hde/vde/hs/vs and the H&V trigger bus,
// with a trigger-cursor overlay and an output frame counter.
// A new delay is only adopted on a vs_in rising edge; DE is then blanked
// for MAX_DELAY ticks while the freshly selected tap settles.
// Ports:
//   clk, reset          : pixel clock, asynchronous active-high reset
//   pc_ena              : sub-pixel phase, a tick is pc_ena == PC_ENA_PHASE
//   delay_sel           : requested delay (0 -> 1, >MAX_DELAY -> MAX_DELAY)
//   hde/vde/hs/vs_in    : raw timing
//   trig_in             : H&V triggers
//   rgb_in              : pixel aligned to the output timing
//   cursor_ena/mask/rgb : overlay enable, trigger mask, colour (ORed on)
//   hde/vde/hs/vs_out   : delayed timing
//   trig_out            : delayed triggers
//   rgb_out             : pixel with overlay
//   frame_cnt           : count of vs_out rising edges (wraps)
//   resync_busy         : high while a delay change is pending or blanking
module vid_timing_delay_pipe
    import vid_pipe_pkg::*;
#(
    parameter int MAX_DELAY    = 16,
    parameter int DEF_DELAY    = 11,
    parameter int TRIG_W       = 48,
    parameter int PC_ENA_PHASE = 0,
    parameter int DW           = $clog2(MAX_DELAY + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        pc_ena,
    input  logic [DW-1:0]     delay_sel,
    input  logic              hde_in,
    input  logic              vde_in,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic [TRIG_W-1:0] trig_in,
    input  logic [23:0]       rgb_in,
    input  logic              cursor_ena,
    input  logic [TRIG_W-1:0] cursor_mask,
    input  logic [23:0]       cursor_rgb,
    output logic              hde_out,
    output logic              vde_out,
    output logic              hs_out,
    output logic              vs_out,
    output logic [TRIG_W-1:0] trig_out,
    output logic [23:0]       rgb_out,
    output logic [15:0]       frame_cnt,
    output logic              resync_busy
);

    localparam int PW = 4 + TRIG_W;

    logic           tick;
    logic [DW-1:0]  req_delay;
    state_t         state_reg, state_next;
    logic [DW-1:0]  active_delay_reg, active_delay_next;
    logic [DW-1:0]  pending_delay_reg, pending_delay_next;
    logic [DW-1:0]  blank_cnt_reg, blank_cnt_next;
    logic           vs_prev_reg;
    logic           vs_rise;
    logic           blank_force;
    logic           blank_reg;
    logic           hit;
    logic [PW-1:0]  pipe_in, pipe_out;
    logic [TRIG_W:0] peek;      // {vs, trig} of the stage about to be loaded
    rgb24_t         rgb_reg;
    logic [15:0]    frame_cnt_reg;

    assign tick      = (pc_ena == 4'(PC_ENA_PHASE));
    assign req_delay = DW'(clamp_delay(32'(delay_sel), MAX_DELAY));
    assign vs_rise   = vs_in & ~vs_prev_reg;

    always_comb begin
        state_next         = state_reg;
        active_delay_next  = active_delay_reg;
        pending_delay_next = pending_delay_reg;
        blank_cnt_next     = blank_cnt_reg;
        case (state_reg)
            RUN: begin
                if (req_delay != active_delay_reg) begin
                    pending_delay_next = req_delay;
                    state_next         = PENDING;
                end
            end
            PENDING: begin
                pending_delay_next = req_delay;
                if (req_delay == active_delay_reg) begin
                    state_next = RUN;
                end else if (vs_rise) begin
                    active_delay_next = pending_delay_reg;
                    blank_cnt_next    = DW'(MAX_DELAY);
                    state_next        = BLANK;
                end
            end
            BLANK: begin
                blank_cnt_next = blank_cnt_reg - 1'b1;
                if (blank_cnt_next == '0)
                    state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // The output being loaded on this tick is blanked whenever the machine
    // will be in BLANK afterwards; this covers the switch-over tick itself
    // and gives exactly MAX_DELAY blanked outputs.
    assign blank_force = (state_next == BLANK);
    assign hit = cursor_ena & ~blank_force & (|(peek[TRIG_W-1:0] & cursor_mask));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= RUN;
            active_delay_reg  <= DW'(DEF_DELAY);
            pending_delay_reg <= DW'(DEF_DELAY);
            blank_cnt_reg     <= '0;
            vs_prev_reg       <= 1'b0;
            blank_reg         <= 1'b0;
            rgb_reg           <= '0;
            frame_cnt_reg     <= '0;
        end else if (tick) begin
            state_reg         <= state_next;
            active_delay_reg  <= active_delay_next;
            pending_delay_reg <= pending_delay_next;
            blank_cnt_reg     <= blank_cnt_next;
            vs_prev_reg       <= vs_in;
            blank_reg         <= blank_force;
            rgb_reg           <= rgb_in | (hit ? cursor_rgb : 24'h000000);
            if (peek[TRIG_W] && !pipe_out[TRIG_W])
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign pipe_in = {hde_in, vde_in, hs_in, vs_in, trig_in};

    // Tap follows the next active delay so a switch uses the new tap on
    // the very tick it is adopted.
    vid_tap_delay #(
        .WIDTH  (PW),
        .DEPTH  (MAX_DELAY),
        .PEEK_W (TRIG_W + 1),
        .DW     (DW)
    ) u_tap (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .din   (pipe_in),
        .tap   (active_delay_next),
        .peek  (peek),
        .dout  (pipe_out)
    );

    assign hde_out     = pipe_out[TRIG_W+3] & ~blank_reg;
    assign vde_out     = pipe_out[TRIG_W+2] & ~blank_reg;
    assign hs_out      = pipe_out[TRIG_W+1];
    assign vs_out      = pipe_out[TRIG_W];
    assign trig_out    = pipe_out[TRIG_W-1:0];
    assign rgb_out     = rgb_reg;
    assign frame_cnt   = frame_cnt_reg;
    assign resync_busy = (state_reg != RUN);

endmodule
